tl_ui_arbiter2: RTL and testbench

//  2:1 TileLink-UL A/D arbiter that feeds the single slave port of the DDR3 UI bridge.

---
 rtl/tl_pkg.sv | 44 ++++
 rtl/tl_a_slice.sv | 50 +++++
 rtl/tl_ui_arbiter2.sv | 157 +++++++++++++++
 tb/tb_tl_ui_arbiter2.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// TileLink-UL types and constants shared by the UI arbiter, its A-channel slice and benches.
package tl_pkg;

  localparam int unsigned TL_RS = 4;
  localparam int unsigned TL_AW = 28;
  localparam int unsigned TL_SW = TL_RS + 1;
  localparam int unsigned TL_DW = 32;
  localparam int unsigned TL_MW = 4;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [3:0]       size;
    logic [TL_SW-1:0] source;
    logic [TL_AW-1:0] address;
    logic [TL_MW-1:0] mask;
    logic [TL_DW-1:0] data;
    logic             corrupt;
  } tl_a_t;

  // A-channel payload minus source; source is carried separately so its width can vary
  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [3:0]       size;
    logic [TL_AW-1:0] address;
    logic [TL_MW-1:0] mask;
    logic [TL_DW-1:0] data;
    logic             corrupt;
  } tl_a_body_t;

  // Prepend the master index so responses can be steered back
  function automatic logic [TL_SW-1:0] tl_tag_source(input logic sel,
                                                     input logic [TL_RS-1:0] src);
    return {sel, src};
  endfunction

endpackage

// File: rtl/tl_a_slice.sv
// One-entry A-channel register: refills whenever empty or drained, payload held while stalled.
module tl_a_slice
  import tl_pkg::*;
#(
  parameter int unsigned SRC_W = TL_SW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             take_i,
  input  tl_a_body_t       body_i,
  input  logic [SRC_W-1:0] src_i,
  output logic             valid_o,
  output tl_a_body_t       body_o,
  output logic [SRC_W-1:0] src_o
);

  logic             valid_q, valid_d;
  tl_a_body_t       body_q, body_d;
  logic [SRC_W-1:0] src_q, src_d;

  always_comb begin
    valid_d = valid_q;
    body_d  = body_q;
    src_d   = src_q;
    if (load_i) begin
      valid_d = take_i;
      if (take_i) begin
        body_d = body_i;
        src_d  = src_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // Payload needs no reset: it is only observed while valid_q is set
  always_ff @(posedge clk) begin
    body_q <= body_d;
    src_q  <= src_d;
  end

  assign valid_o = valid_q;
  assign body_o  = body_q;
  assign src_o   = src_q;

endmodule

// File: rtl/tl_ui_arbiter2.sv
// 2:1 TileLink-UL arbiter in front of the DDR3 UI bridge: round-robin A with source tagging, D demux.
module tl_ui_arbiter2
  import tl_pkg::*;
(
  input  logic             tilelink_clock_i,
  input  logic             tilelink_reset_i,

  input  logic [2:0]       m0_a_opcode,
  input  logic [2:0]       m0_a_param,
  input  logic [3:0]       m0_a_size,
  input  logic [TL_RS-1:0] m0_a_source,
  input  logic [TL_AW-1:0] m0_a_address,
  input  logic [3:0]       m0_a_mask,
  input  logic [31:0]      m0_a_data,
  input  logic             m0_a_corrupt,
  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [1:0]       m0_d_param,
  output logic [3:0]       m0_d_size,
  output logic [TL_RS-1:0] m0_d_source,
  output logic             m0_d_denied,
  output logic             m0_d_corrupt,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,

  input  logic [2:0]       m1_a_opcode,
  input  logic [2:0]       m1_a_param,
  input  logic [3:0]       m1_a_size,
  input  logic [TL_RS-1:0] m1_a_source,
  input  logic [TL_AW-1:0] m1_a_address,
  input  logic [3:0]       m1_a_mask,
  input  logic [31:0]      m1_a_data,
  input  logic             m1_a_corrupt,
  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [1:0]       m1_d_param,
  output logic [3:0]       m1_d_size,
  output logic [TL_RS-1:0] m1_d_source,
  output logic             m1_d_denied,
  output logic             m1_d_corrupt,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,

  output logic [2:0]       ddr3_a_opcode,
  output logic [2:0]       ddr3_a_param,
  output logic [3:0]       ddr3_a_size,
  output logic [TL_RS:0]   ddr3_a_source,
  output logic [TL_AW-1:0] ddr3_a_address,
  output logic [3:0]       ddr3_a_mask,
  output logic [31:0]      ddr3_a_data,
  output logic             ddr3_a_corrupt,
  output logic             ddr3_a_valid,
  input  logic             ddr3_a_ready,
  input  logic [2:0]       ddr3_d_opcode,
  input  logic [1:0]       ddr3_d_param,
  input  logic [3:0]       ddr3_d_size,
  input  logic [TL_RS:0]   ddr3_d_source,
  input  logic             ddr3_d_denied,
  input  logic             ddr3_d_corrupt,
  input  logic [31:0]      ddr3_d_data,
  input  logic             ddr3_d_valid,
  output logic             ddr3_d_ready
);

  logic             clk, rst;
  logic             load, take, grant;
  logic             last_grant_q, last_grant_d;
  logic             a_valid;
  tl_a_body_t       m0_body, m1_body, sel_body, a_body;
  logic [TL_SW-1:0] sel_src, a_src;
  tl_a_t            a_out;
  logic             d_sel;

  assign clk = tilelink_clock_i;
  assign rst = tilelink_reset_i;

  assign m0_body = '{opcode: m0_a_opcode, param: m0_a_param, size: m0_a_size,
                     address: m0_a_address, mask: m0_a_mask, data: m0_a_data,
                     corrupt: m0_a_corrupt};
  assign m1_body = '{opcode: m1_a_opcode, param: m1_a_param, size: m1_a_size,
                     address: m1_a_address, mask: m1_a_mask, data: m1_a_data,
                     corrupt: m1_a_corrupt};

  // Round-robin grant: a tie goes to the master that did not win last
  always_comb begin
    load  = !a_valid || ddr3_a_ready;
    grant = 1'b0;
    if (m0_a_valid && m1_a_valid) grant = !last_grant_q;
    else if (m1_a_valid)          grant = 1'b1;
    take         = !rst && load && (m0_a_valid || m1_a_valid);
    m0_a_ready   = take && !grant;
    m1_a_ready   = take && grant;
    last_grant_d = take ? grant : last_grant_q;
    sel_body     = grant ? m1_body : m0_body;
    sel_src      = tl_tag_source(grant, grant ? m1_a_source : m0_a_source);
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

  tl_a_slice #(
    .SRC_W (TL_SW)
  ) u_a_slice (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .take_i  (take),
    .body_i  (sel_body),
    .src_i   (sel_src),
    .valid_o (a_valid),
    .body_o  (a_body),
    .src_o   (a_src)
  );

  assign a_out = '{opcode: a_body.opcode, param: a_body.param, size: a_body.size,
                   source: a_src, address: a_body.address, mask: a_body.mask,
                   data: a_body.data, corrupt: a_body.corrupt};

  assign ddr3_a_opcode  = a_out.opcode;
  assign ddr3_a_param   = a_out.param;
  assign ddr3_a_size    = a_out.size;
  assign ddr3_a_source  = a_out.source;
  assign ddr3_a_address = a_out.address;
  assign ddr3_a_mask    = a_out.mask;
  assign ddr3_a_data    = a_out.data;
  assign ddr3_a_corrupt = a_out.corrupt;
  assign ddr3_a_valid   = a_valid;

  // D demux depends only on D-side signals, keeping A and D free of combinational coupling
  always_comb begin
    d_sel        = ddr3_d_source[TL_RS];
    m0_d_opcode  = ddr3_d_opcode;
    m0_d_param   = ddr3_d_param;
    m0_d_size    = ddr3_d_size;
    m0_d_source  = ddr3_d_source[TL_RS-1:0];
    m0_d_denied  = ddr3_d_denied;
    m0_d_corrupt = ddr3_d_corrupt;
    m0_d_data    = ddr3_d_data;
    m0_d_valid   = ddr3_d_valid && !d_sel;
    m1_d_opcode  = ddr3_d_opcode;
    m1_d_param   = ddr3_d_param;
    m1_d_size    = ddr3_d_size;
    m1_d_source  = ddr3_d_source[TL_RS-1:0];
    m1_d_denied  = ddr3_d_denied;
    m1_d_corrupt = ddr3_d_corrupt;
    m1_d_data    = ddr3_d_data;
    m1_d_valid   = ddr3_d_valid && d_sel;
    ddr3_d_ready = d_sel ? m1_d_ready : m0_d_ready;
  end

endmodule

// File: tb/tb_tl_ui_arbiter2.sv
// Directed bench for tl_ui_arbiter2: per-cycle behavioural model plus hand-computed pinned values.
module tb_tl_ui_arbiter2;
  import tl_pkg::*;

  logic clk, rst;
  logic [2:0] m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
  logic [3:0] m0_a_size, m1_a_size, m0_a_mask, m1_a_mask;
  logic [3:0] m0_a_source, m1_a_source;
  logic [27:0] m0_a_address, m1_a_address;
  logic [31:0] m0_a_data, m1_a_data;
  logic m0_a_corrupt, m1_a_corrupt, m0_a_valid, m1_a_valid, m0_a_ready, m1_a_ready;
  logic [2:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_param, m1_d_param;
  logic [3:0] m0_d_size, m1_d_size, m0_d_source, m1_d_source;
  logic m0_d_denied, m1_d_denied, m0_d_corrupt, m1_d_corrupt, m0_d_valid, m1_d_valid;
  logic [31:0] m0_d_data, m1_d_data;
  logic m0_d_ready, m1_d_ready;
  logic [2:0] ddr3_a_opcode, ddr3_a_param, ddr3_d_opcode;
  logic [3:0] ddr3_a_size, ddr3_a_mask, ddr3_d_size;
  logic [4:0] ddr3_a_source, ddr3_d_source;
  logic [27:0] ddr3_a_address;
  logic [31:0] ddr3_a_data, ddr3_d_data;
  logic ddr3_a_corrupt, ddr3_a_valid, ddr3_a_ready;
  logic [1:0] ddr3_d_param;
  logic ddr3_d_denied, ddr3_d_corrupt, ddr3_d_valid, ddr3_d_ready;

  tl_ui_arbiter2 dut (
    .tilelink_clock_i(clk), .tilelink_reset_i(rst),
    .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param), .m0_a_size(m0_a_size),
    .m0_a_source(m0_a_source), .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask),
    .m0_a_data(m0_a_data), .m0_a_corrupt(m0_a_corrupt), .m0_a_valid(m0_a_valid),
    .m0_a_ready(m0_a_ready), .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param),
    .m0_d_size(m0_d_size), .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied),
    .m0_d_corrupt(m0_d_corrupt), .m0_d_data(m0_d_data), .m0_d_valid(m0_d_valid),
    .m0_d_ready(m0_d_ready),
    .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param), .m1_a_size(m1_a_size),
    .m1_a_source(m1_a_source), .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask),
    .m1_a_data(m1_a_data), .m1_a_corrupt(m1_a_corrupt), .m1_a_valid(m1_a_valid),
    .m1_a_ready(m1_a_ready), .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param),
    .m1_d_size(m1_d_size), .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied),
    .m1_d_corrupt(m1_d_corrupt), .m1_d_data(m1_d_data), .m1_d_valid(m1_d_valid),
    .m1_d_ready(m1_d_ready),
    .ddr3_a_opcode(ddr3_a_opcode), .ddr3_a_param(ddr3_a_param), .ddr3_a_size(ddr3_a_size),
    .ddr3_a_source(ddr3_a_source), .ddr3_a_address(ddr3_a_address),
    .ddr3_a_mask(ddr3_a_mask), .ddr3_a_data(ddr3_a_data), .ddr3_a_corrupt(ddr3_a_corrupt),
    .ddr3_a_valid(ddr3_a_valid), .ddr3_a_ready(ddr3_a_ready),
    .ddr3_d_opcode(ddr3_d_opcode), .ddr3_d_param(ddr3_d_param), .ddr3_d_size(ddr3_d_size),
    .ddr3_d_source(ddr3_d_source), .ddr3_d_denied(ddr3_d_denied),
    .ddr3_d_corrupt(ddr3_d_corrupt), .ddr3_d_data(ddr3_d_data),
    .ddr3_d_valid(ddr3_d_valid), .ddr3_d_ready(ddr3_d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int F_A_VALID = 0, F_A_SRC = 1, F_A_DATA = 2, F_A_MASK = 3, F_A_CORRUPT = 4,
                 F_A_OPCODE = 5, F_A_ADDR = 6, F_M0_RDY = 7, F_M1_RDY = 8, F_M0_DV = 9,
                 F_M1_DV = 10, F_M0_DSRC = 11, F_M1_DSRC = 12, F_D_RDY = 13, F_M1_DDATA = 14;
  localparam int NPIN = 4;

  int checks = 0;
  int failures = 0;

  // Literal expectations written by the stimulus, read by the compare process
  bit          pin_en [NPIN];
  int          pin_sel[NPIN];
  logic [31:0] pin_val[NPIN];

  // Model state: holding register contents and whose turn it is on a tie
  bit    m_av = 1'b0;
  int    m_turn = 0;
  tl_a_t m_a;

  function automatic int model_winner();
    if (rst) return -1;
    if (m_av && !ddr3_a_ready) return -1;
    if (m0_a_valid && m1_a_valid) return m_turn;
    if (m0_a_valid) return 0;
    if (m1_a_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int    w;
    tl_a_t p;
    w = model_winner();
    if (rst) begin
      m_av   <= 1'b0;
      m_turn <= 0;
    end else if (!m_av || ddr3_a_ready) begin
      if (w == 0) begin
        p = '{opcode: m0_a_opcode, param: m0_a_param, size: m0_a_size,
              source: 5'(m0_a_source), address: m0_a_address, mask: m0_a_mask,
              data: m0_a_data, corrupt: m0_a_corrupt};
      end else begin
        p = '{opcode: m1_a_opcode, param: m1_a_param, size: m1_a_size,
              source: 5'(16 + int'(m1_a_source)), address: m1_a_address, mask: m1_a_mask,
              data: m1_a_data, corrupt: m1_a_corrupt};
      end
      if (w >= 0) begin
        m_av   <= 1'b1;
        m_a    <= p;
        m_turn <= 1 - w;
      end else begin
        m_av <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] get_field(input int sel);
    case (sel)
      F_A_VALID:   return 32'(ddr3_a_valid);
      F_A_SRC:     return 32'(ddr3_a_source);
      F_A_DATA:    return ddr3_a_data;
      F_A_MASK:    return 32'(ddr3_a_mask);
      F_A_CORRUPT: return 32'(ddr3_a_corrupt);
      F_A_OPCODE:  return 32'(ddr3_a_opcode);
      F_A_ADDR:    return 32'(ddr3_a_address);
      F_M0_RDY:    return 32'(m0_a_ready);
      F_M1_RDY:    return 32'(m1_a_ready);
      F_M0_DV:     return 32'(m0_d_valid);
      F_M1_DV:     return 32'(m1_d_valid);
      F_M0_DSRC:   return 32'(m0_d_source);
      F_M1_DSRC:   return 32'(m1_d_source);
      F_D_RDY:     return 32'(ddr3_d_ready);
      default:     return m1_d_data;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: mid-cycle, after inputs settle and registers have updated
  always @(negedge clk) begin
    int w;
    bit to1;
    #3;
    w   = model_winner();
    to1 = int'(ddr3_d_source) >= 16;
    check("m0_a_ready", 32'(m0_a_ready), 32'(w == 0));
    check("m1_a_ready", 32'(m1_a_ready), 32'(w == 1));
    check("ddr3_a_valid", 32'(ddr3_a_valid), 32'(m_av));
    if (m_av) begin
      check("a_opcode", 32'(ddr3_a_opcode), 32'(m_a.opcode));
      check("a_param", 32'(ddr3_a_param), 32'(m_a.param));
      check("a_size", 32'(ddr3_a_size), 32'(m_a.size));
      check("a_source", 32'(ddr3_a_source), 32'(m_a.source));
      check("a_address", 32'(ddr3_a_address), 32'(m_a.address));
      check("a_mask", 32'(ddr3_a_mask), 32'(m_a.mask));
      check("a_data", ddr3_a_data, m_a.data);
      check("a_corrupt", 32'(ddr3_a_corrupt), 32'(m_a.corrupt));
    end
    check("m0_d_valid", 32'(m0_d_valid), 32'(ddr3_d_valid && !to1));
    check("m1_d_valid", 32'(m1_d_valid), 32'(ddr3_d_valid && to1));
    check("ddr3_d_ready", 32'(ddr3_d_ready), 32'(to1 ? m1_d_ready : m0_d_ready));
    check("m0_d_source", 32'(m0_d_source), 32'(int'(ddr3_d_source) % 16));
    check("m1_d_source", 32'(m1_d_source), 32'(int'(ddr3_d_source) % 16));
    check("m0_d_payload", {m0_d_opcode, m0_d_param, m0_d_size, m0_d_denied, m0_d_corrupt},
          {ddr3_d_opcode, ddr3_d_param, ddr3_d_size, ddr3_d_denied, ddr3_d_corrupt});
    check("m1_d_payload", {m1_d_opcode, m1_d_param, m1_d_size, m1_d_denied, m1_d_corrupt},
          {ddr3_d_opcode, ddr3_d_param, ddr3_d_size, ddr3_d_denied, ddr3_d_corrupt});
    check("m0_d_data", m0_d_data, ddr3_d_data);
    check("m1_d_data", m1_d_data, ddr3_d_data);
    for (int i = 0; i < NPIN; i++)
      if (pin_en[i]) check($sformatf("pinned_field%0d", pin_sel[i]),
                           get_field(pin_sel[i]), pin_val[i]);
  end

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < NPIN; i++) pin_en[i] = 1'b0;
  endtask

  task automatic pin(input int slot, input int sel, input logic [31:0] val);
    pin_en[slot]  = 1'b1;
    pin_sel[slot] = sel;
    pin_val[slot] = val;
  endtask

  task automatic drive(input int k, input logic v, input logic [2:0] op, input logic [2:0] par,
                       input logic [3:0] sz, input logic [3:0] src, input logic [27:0] addr,
                       input logic [3:0] msk, input logic [31:0] dat, input logic cor);
    if (k == 0) begin
      m0_a_valid = v; m0_a_opcode = op; m0_a_param = par; m0_a_size = sz; m0_a_source = src;
      m0_a_address = addr; m0_a_mask = msk; m0_a_data = dat; m0_a_corrupt = cor;
    end else begin
      m1_a_valid = v; m1_a_opcode = op; m1_a_param = par; m1_a_size = sz; m1_a_source = src;
      m1_a_address = addr; m1_a_mask = msk; m1_a_data = dat; m1_a_corrupt = cor;
    end
  endtask

  task automatic drive_d(input logic v, input logic [2:0] op, input logic [4:0] src,
                         input logic [31:0] dat);
    ddr3_d_valid = v; ddr3_d_opcode = op; ddr3_d_source = src; ddr3_d_data = dat;
  endtask

  initial begin
    for (int i = 0; i < NPIN; i++) begin
      pin_en[i] = 1'b0; pin_sel[i] = 0; pin_val[i] = '0;
    end
    rst = 1'b1;
    ddr3_a_ready = 1'b1;
    m0_d_ready = 1'b0; m1_d_ready = 1'b0;
    ddr3_d_param = 2'd1; ddr3_d_size = 4'd2; ddr3_d_denied = 1'b0; ddr3_d_corrupt = 1'b1;
    drive(0, 1'b0, TL_GET, 3'd0, 4'd2, 4'd0, 28'h0, 4'hF, 32'h0, 1'b0);
    drive(1, 1'b0, TL_GET, 3'd0, 4'd2, 4'd0, 28'h0, 4'hF, 32'h0, 1'b0);
    drive_d(1'b0, TL_ACK, 5'h00, 32'h0);
    step(); step();
    rst = 1'b0;
    pin(0, F_A_VALID, 0);

    // Lone m0 Get; m1 never readied
    step();
    drive(0, 1'b1, TL_GET, 3'd0, 4'd2, 4'd3, 28'h100, 4'hF, 32'h0, 1'b0);
    pin(0, F_M0_RDY, 1); pin(1, F_M1_RDY, 0);
    step();
    m0_a_valid = 1'b0;
    pin(0, F_A_SRC, 32'h03); pin(1, F_A_VALID, 1); pin(2, F_A_ADDR, 32'h100); pin(3, F_M1_RDY, 0);
    step();
    pin(0, F_A_VALID, 0);

    // Contention after reset alternates 0,1,0,1,0,1 at one beat per cycle
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      drive(0, 1'b1, TL_PUT_FULL, 3'd0, 4'd2, 4'hA, 28'h0000400 + 28'(i), 4'hF,
            32'h000000A0 + 32'(i), 1'b0);
      drive(1, 1'b1, TL_GET, 3'd0, 4'd2, 4'h5, 28'h0000800 + 28'(i), 4'hF,
            32'h00000B00 + 32'(i), 1'b0);
      pin(0, (i % 2 == 0) ? F_M0_RDY : F_M1_RDY, 1);
      if (i > 0) begin
        pin(1, F_A_SRC, ((i - 1) % 2 == 0) ? 32'h0A : 32'h15);
        pin(2, F_A_VALID, 1);
      end
    end
    step();
    m0_a_valid = 1'b0; m1_a_valid = 1'b0;
    pin(0, F_A_SRC, 32'h15); pin(1, F_A_DATA, 32'h00000B05);

    // Stall: register frozen, no readies; release grants m1 next
    step();
    drive(0, 1'b1, TL_PUT_FULL, 3'd0, 4'd2, 4'hA, 28'h10, 4'hF, 32'h11111111, 1'b0);
    pin(0, F_M0_RDY, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      ddr3_a_ready = 1'b0;
      drive(0, 1'b1, TL_PUT_FULL, 3'd0, 4'd2, 4'hA, 28'h14, 4'hF, 32'h33333333, 1'b0);
      drive(1, 1'b1, TL_PUT_FULL, 3'd0, 4'd2, 4'h5, 28'h20, 4'hF, 32'h22222222, 1'b0);
      pin(0, F_M0_RDY, 0); pin(1, F_M1_RDY, 0); pin(2, F_A_DATA, 32'h11111111);
    end
    step();
    ddr3_a_ready = 1'b1;
    pin(0, F_M1_RDY, 1); pin(1, F_M0_RDY, 0); pin(2, F_A_DATA, 32'h11111111);
    step();
    m1_a_valid = 1'b0;
    pin(0, F_A_SRC, 32'h15); pin(1, F_A_DATA, 32'h22222222); pin(2, F_M0_RDY, 1);
    step();
    m0_a_valid = 1'b0;
    pin(0, F_A_DATA, 32'h33333333); pin(1, F_A_SRC, 32'h0A);

    // D responses steered by the source MSB, alongside an A accept
    step();
    drive_d(1'b1, TL_ACK_DATA, 5'h12, 32'hDEADBEEF);
    m1_d_ready = 1'b1; m0_d_ready = 1'b0;
    drive(0, 1'b1, TL_PUT_FULL, 3'd0, 4'd2, 4'hA, 28'h200, 4'hF, 32'h44444444, 1'b0);
    pin(0, F_M1_DV, 1); pin(1, F_M1_DSRC, 2); pin(2, F_M0_DV, 0); pin(3, F_D_RDY, 1);
    step();
    m0_a_valid = 1'b0;
    m1_d_ready = 1'b0; m0_d_ready = 1'b1;
    pin(0, F_D_RDY, 0); pin(1, F_M1_DDATA, 32'hDEADBEEF); pin(2, F_A_DATA, 32'h44444444);
    step();
    drive_d(1'b1, TL_ACK, 5'h07, 32'h0);
    pin(0, F_M0_DV, 1); pin(1, F_M0_DSRC, 7); pin(2, F_M1_DV, 0); pin(3, F_D_RDY, 1);
    step();
    ddr3_d_valid = 1'b0;
    pin(0, F_M0_DV, 0);

    // Reset with a beat held: beat dropped, master 0 wins first afterwards
    step();
    drive(0, 1'b1, TL_PUT_FULL, 3'd0, 4'd2, 4'hA, 28'h300, 4'hF, 32'h55555555, 1'b0);
    step();
    rst = 1'b1; ddr3_a_ready = 1'b0;
    drive(1, 1'b1, TL_GET, 3'd0, 4'd2, 4'h5, 28'h304, 4'hF, 32'h66666666, 1'b0);
    pin(0, F_M0_RDY, 0); pin(1, F_M1_RDY, 0); pin(2, F_A_VALID, 1);
    step();
    rst = 1'b0; ddr3_a_ready = 1'b1;
    pin(0, F_A_VALID, 0); pin(1, F_M0_RDY, 1); pin(2, F_M1_RDY, 0);
    step();
    m0_a_valid = 1'b0; m1_a_valid = 1'b0;
    pin(0, F_A_SRC, 32'h0A); pin(1, F_A_VALID, 1);

    // PutPartial with corrupt from m1 passes through untouched
    step();
    drive(1, 1'b1, TL_PUT_PARTIAL, 3'd0, 4'd2, 4'h5, 28'h3000, 4'b0110, 32'hCAFEF00D, 1'b1);
    pin(0, F_M1_RDY, 1);
    step();
    m1_a_valid = 1'b0;
    pin(0, F_A_OPCODE, 32'(TL_PUT_PARTIAL)); pin(1, F_A_MASK, 32'h6);
    pin(2, F_A_CORRUPT, 1); pin(3, F_A_SRC, 32'h15);
    step();
    pin(0, F_A_VALID, 0);
    step(); step();
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
